accumulate: RTL and testbench

//   Downstream stage of the multiply block. Consumes its stream of signed

---
 rtl/accumulate_pkg.sv | 27 ++
 rtl/accumulate_if.sv | 19 +
 rtl/accumulate.sv | 61 ++++++
 tb/tb_accumulate.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/accumulate_pkg.sv
// accumulate_pkg: shared width helper and signed saturation, also reused by the activation stage
//   clog2(n)            ceil(log2(n)), 0 for n <= 1; elaboration-time width math
//   sat(v, resw, accw)  clamp signed v (accw significant bits) into resw signed bits
package accumulate_pkg;

    localparam int MAXW = 128;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Operates on a wide carrier so one function serves every width pair;
    // callers sign-extend in and truncate out.
    function automatic logic signed [MAXW-1:0] sat(input logic signed [MAXW-1:0] v,
                                                   input int resw, input int accw);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        hi = '0;
        hi[resw-1] = 1'b1;
        hi = hi - MAXW'(1);
        lo = ~hi;
        return (resw >= accw) ? v : (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/accumulate_if.sv
// accumulate_if: product input and sum output strobe/ready handshakes
//   arg_stb  product valid            arg_dat  signed product
//   arg_rdy  block accepts product    res_stb  sum valid
//   res_dat  signed saturated sum     res_rdy  consumer accepts sum
//   master: the environment driving products and consuming sums; slave: accumulate
interface accumulate_if #(
    parameter int ARGW = 32,
    parameter int RESW = 32
);
    logic                   arg_stb;
    logic signed [ARGW-1:0] arg_dat;
    logic                   arg_rdy;
    logic                   res_stb;
    logic        [RESW-1:0] res_dat;
    logic                   res_rdy;

    modport master(output arg_stb, arg_dat, res_rdy, input arg_rdy, res_stb, res_dat);
    modport slave(input arg_stb, arg_dat, res_rdy, output arg_rdy, res_stb, res_dat);
endinterface

// File: rtl/accumulate.sv
// accumulate: sums every N consecutive signed products and emits the sum saturated to RESW bits
//   clk  clock
//   rst  synchronous active-high reset; drops any partial sum and pending result
//   bus  accumulate_if.slave: products in on arg_*, sums out on res_*
module accumulate
    import accumulate_pkg::*;
#(
    parameter int ARGW = 32,
    parameter int N    = 4,
    parameter int RESW = 32
) (
    input logic         clk,
    input logic         rst,
    accumulate_if.slave bus
);
    localparam int ACCW = ARGW + clog2(N);
    localparam int CW   = N > 1 ? clog2(N) : 1;

    logic        [CW-1:0]   cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_sum;
    logic                   res_stb;
    logic        [RESW-1:0] res_dat;
    logic                   last;
    logic                   res_bsy;
    logic                   arg_ack;

    assign last    = cnt == CW'(N - 1);
    assign res_bsy = res_stb & ~bus.res_rdy;
    // Only the final term needs the output register, so earlier terms keep
    // flowing while a previous sum waits for the consumer.
    assign bus.arg_rdy = ~(last & res_bsy);
    assign arg_ack     = bus.arg_stb & bus.arg_rdy;
    // The first term of a group restarts from zero instead of clearing acc on emit.
    assign acc_sum     = (cnt == '0 ? '0 : acc) + ACCW'(bus.arg_dat);
    assign bus.res_stb = res_stb;
    assign bus.res_dat = res_dat;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (arg_ack) cnt <= last ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else if (arg_ack && !last) acc <= acc_sum;
    end

    // A new final term wins over the consumer's ack of the previous sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_stb <= 1'b0;
        end else if (arg_ack && last) begin
            res_stb <= 1'b1;
            res_dat <= RESW'(sat(MAXW'(acc_sum), RESW, ACCW));
        end else if (bus.res_rdy) begin
            res_stb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulate.sv
// tb_accumulate: randomized and directed scoreboard bench for accumulate
module tb_accumulate;
    localparam int ARGW = 32;
    localparam int N    = 4;
    localparam int RESW = 32;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accumulate_if #(.ARGW(ARGW), .RESW(RESW)) bus();
    accumulate #(.ARGW(ARGW), .N(N), .RESW(RESW)) dut(.clk(clk), .rst(rst), .bus(bus));

    exp_t        sb[$];
    longint      grp[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          open  = 1'b0;
    logic [31:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum of the group, clamped to the signed result range.
    function automatic logic [31:0] ref_sum();
        longint s = 0;
        foreach (grp[i]) s += grp[i];
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    task automatic cycle(input bit stb, input logic [31:0] dat, input bit rdy, output bit ack);
        @(negedge clk);
        bus.arg_stb = stb;
        bus.arg_dat = stb ? dat : $urandom;
        bus.res_rdy = rdy;
        #1;
        ack = stb && bus.arg_rdy;
        if (ack) begin
            grp.push_back(longint'(signed'(dat)));
            if (grp.size() == N) begin
                sb.push_back('{ref_sum(), cyc});
                grp.delete();
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input bit rdy, output int waits);
        bit a;
        waits = 0;
        cycle(1'b1, d, rdy, a);
        while (!a && waits < 50) begin
            waits++;
            cycle(1'b1, d, rdy, a);
        end
        if (!a) check("send_ack", a, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, a);
    endtask

    task automatic send_nowait(input logic [31:0] d, input bit rdy, input string name);
        int w;
        send(d, rdy, w);
        check(name, w, 0);
    endtask

    // Monitor: new results must appear the cycle after their final ack,
    // held results must not change, accepted results must match the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                open = 1'b0;
                continue;
            end
            if (bus.res_stb) begin
                if (open) check("hold_dat", bus.res_dat, held);
                else if (sb.size() == 0) check("unexpected_res", bus.res_stb, 0);
                else check("latency", cyc, sb[0].cyc + 1);
                if (bus.res_rdy) begin
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("res_dat", bus.res_dat, e.dat);
                    end
                    open = 1'b0;
                end else begin
                    open = 1'b1;
                    held = bus.res_dat;
                end
            end else begin
                if (open) check("hold_stb", bus.res_stb, 1);
                open = 1'b0;
            end
        end
    end

    initial begin
        bit a;
        int w;
        bus.arg_stb = 1'b0;
        bus.arg_dat = '0;
        bus.res_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_res_stb", bus.res_stb, 0);
        rst = 1'b0;
        #1;
        check("reset_arg_rdy", bus.arg_rdy, 1);

        for (int v = 1; v <= 4; v++) send_nowait(32'(v), 1'b1, "t1_ack");
        idle(2);
        check("t1_stb_pulse", bus.res_stb, 0);

        send_nowait(-32'sd5, 1'b1, "t2_ack");
        send_nowait(32'd3, 1'b1, "t2_ack");
        send_nowait(-32'sd1, 1'b1, "t2_ack");
        send_nowait(32'd0, 1'b1, "t2_ack");
        idle(2);

        repeat (4) send_nowait(32'h7FFFFFFF, 1'b1, "t3_ack");
        repeat (4) send_nowait(32'h80000000, 1'b1, "t3_ack");
        idle(2);

        for (int v = 1; v <= 4; v++) send_nowait(32'(v), 1'b0, "t4_ack");
        repeat (3) send_nowait(32'd5, 1'b0, "t4_nonfinal");
        cycle(1'b1, 32'd5, 1'b0, a);
        check("t4_block", a, 0);
        cycle(1'b1, 32'd5, 1'b0, a);
        check("t4_block", a, 0);
        send_nowait(32'd5, 1'b1, "t4_release");
        idle(3);

        send_nowait(32'd7, 1'b1, "t5_ack");
        send_nowait(32'd7, 1'b1, "t5_ack");
        @(negedge clk);
        rst = 1'b1;
        bus.arg_stb = 1'b0;
        grp.delete();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) send_nowait(32'd1, 1'b1, "t5_ack");
        idle(2);

        for (int v = 1; v <= 8; v++) send_nowait(32'(v), 1'b1, "t6_no_stall");
        idle(2);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 3);
            d = r == 0 ? 32'h7FFFFFFF : r == 1 ? 32'h80000000 : $urandom;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, a);
        end
        w = 0;
        while (sb.size() > 0 && w < 50) begin
            idle(1);
            w++;
        end
        idle(2);
        check("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
